// File: rtl/instruction_loader.sv
// rtl/instruction_loader.sv - byte-stream boot loader that fills instruction memory
// Optional end-of-load checksum byte: define LOADER_CHECKSUM_EN.
module instruction_loader #(
  parameter int IM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        im_we,
  output logic [31:0] im_addr,
  output logic [31:0] im_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        err,
  output logic [15:0] words_written
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR0  = 3'd1;
  localparam logic [2:0] S_HDR1  = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERROR = 3'd6;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHK   = 3'd7;
  localparam logic [2:0] S_END   = S_CHK;
`else
  localparam logic [2:0] S_END   = S_DONE;
`endif

  localparam logic [16:0] MAX_WORDS = 17'(IM_WORDS);

  logic [2:0]  state;
  logic [15:0] n_words;
  logic [1:0]  byte_cnt;
  logic [23:0] shift;
  logic        xfer;
  logic [15:0] ww_next;
  logic [15:0] hdr_n;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  chk_acc;
`endif

  assign xfer    = byte_valid && byte_ready;
  assign ww_next = words_written + 16'd1;
  assign hdr_n   = {n_words[15:8], byte_data};

  always_comb begin
    byte_ready = (state == S_HDR0) || (state == S_HDR1) || (state == S_DATA);
`ifdef LOADER_CHECKSUM_EN
    if (state == S_CHK) byte_ready = 1'b1;
`endif
  end

  assign im_we    = (state == S_WRITE);
  assign done     = (state == S_DONE);
  assign err      = (state == S_ERROR);
  assign cpu_hold = !((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      n_words       <= '0;
      byte_cnt      <= '0;
      shift         <= '0;
      im_addr       <= '0;
      im_wdata      <= '0;
      words_written <= '0;
`ifdef LOADER_CHECKSUM_EN
      chk_acc       <= '0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state         <= S_HDR0;
            words_written <= '0;
            byte_cnt      <= '0;
`ifdef LOADER_CHECKSUM_EN
            chk_acc       <= '0;
`endif
          end
        end
        S_HDR0: begin
          if (xfer) begin
            n_words[15:8] <= byte_data;
            state         <= S_HDR1;
          end
        end
        S_HDR1: begin
          if (xfer) begin
            n_words[7:0] <= byte_data;
            if ({1'b0, hdr_n} > MAX_WORDS) state <= S_ERROR;
            else if (hdr_n == 16'd0)       state <= S_END;
            else                           state <= S_DATA;
          end
        end
        S_DATA: begin
          if (xfer) begin
`ifdef LOADER_CHECKSUM_EN
            chk_acc <= chk_acc ^ byte_data;
`endif
            // byte_cnt wraps to 0 after the fourth byte, ready for the next word
            byte_cnt <= byte_cnt + 2'd1;
            shift    <= {shift[15:0], byte_data};
            if (byte_cnt == 2'd3) begin
              im_wdata <= {shift, byte_data};
              im_addr  <= {14'd0, words_written, 2'b00};
              state    <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          words_written <= ww_next;
          state         <= (ww_next < n_words) ? S_DATA : S_END;
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHK: begin
          if (xfer) state <= (byte_data == chk_acc) ? S_DONE : S_ERROR;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
